// File: rtl/mem_file_loader.sv
// Byte-stream loader/dumper in front of the data memory's file port.
// Words travel high byte first; addresses wrap modulo 2^ADDR_W.
module mem_file_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE, LD_HI, LD_LO, LD_WR, DP_RD, DP_CAP, DP_HI, DP_LO, FIN
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W+1)'(1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] last_addr_reg, last_addr_next;
  logic [ADDR_W:0]   remaining_reg, remaining_next;
  logic [15:0]       wdata_reg, wdata_next;
  logic [15:0]       hold_reg, hold_next;
  logic [ADDR_W:0]   clamped_count;

  assign clamped_count = (word_count > MAX_CNT) ? MAX_CNT : word_count;
  assign mem_wdata     = wdata_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      last_addr_reg <= '0;
      remaining_reg <= '0;
      wdata_reg     <= '0;
      hold_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      last_addr_reg <= last_addr_next;
      remaining_reg <= remaining_next;
      wdata_reg     <= wdata_next;
      hold_reg      <= hold_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    last_addr_next = last_addr_reg;
    remaining_next = remaining_reg;
    wdata_next     = wdata_reg;
    hold_next      = hold_reg;
    rx_ready       = 1'b0;
    tx_valid       = 1'b0;
    tx_data        = 8'h00;
    mem_write_en   = 1'b0;
    // The memory port keeps showing the last address it was driven with.
    mem_addr       = last_addr_reg;
    busy           = (state_reg != IDLE);
    done           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load_start || dump_start) begin
          addr_next      = base_addr;
          remaining_next = clamped_count;
          if (clamped_count == '0) state_next = FIN;
          else if (load_start)     state_next = LD_HI;
          else                     state_next = DP_RD;
        end
      end
      LD_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          wdata_next[15:8] = rx_data;
          state_next       = LD_LO;
        end
      end
      LD_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          wdata_next[7:0] = rx_data;
          state_next      = LD_WR;
        end
      end
      LD_WR: begin
        mem_write_en   = 1'b1;
        mem_addr       = addr_reg;
        last_addr_next = addr_reg;
        addr_next      = addr_reg + ADDR_W'(1);
        remaining_next = remaining_reg - ONE_CNT;
        state_next     = (remaining_reg == ONE_CNT) ? FIN : LD_HI;
      end
      DP_RD: begin
        mem_addr       = addr_reg;
        last_addr_next = addr_reg;
        state_next     = DP_CAP;
      end
      DP_CAP: begin
        // Memory read data is valid one cycle after the address.
        hold_next  = mem_rdata;
        state_next = DP_HI;
      end
      DP_HI: begin
        tx_valid = 1'b1;
        tx_data  = hold_reg[15:8];
        if (tx_ready) state_next = DP_LO;
      end
      DP_LO: begin
        tx_valid = 1'b1;
        tx_data  = hold_reg[7:0];
        if (tx_ready) begin
          addr_next      = addr_reg + ADDR_W'(1);
          remaining_next = remaining_reg - ONE_CNT;
          state_next     = (remaining_reg == ONE_CNT) ? FIN : DP_RD;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_file_loader.sv
// Directed bench for mem_file_loader with a registered-read memory model.
module tb_mem_file_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_start = 1'b0, dump_start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        mem_write_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [256];
  logic [7:0]  wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  logic [7:0]  tx_q [$];
  int          we_double = 0, stall_err = 0, txv_cnt = 0;
  logic        prev_we = 1'b0, prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        tx_rand = 1'b0;

  always #5 clock = ~clock;

  mem_file_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clock(clock), .reset_n(reset_n),
    .load_start(load_start), .dump_start(dump_start),
    .base_addr(base_addr), .word_count(word_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  // Memory model plus stream monitors, sampled at the rising edge.
  always @(posedge clock) begin
    if (mem_write_en) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    mem_rdata <= mem[mem_addr];
    if (prev_we && mem_write_en) we_double++;
    prev_we = mem_write_en;
    if (tx_valid) txv_cnt++;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (prev_stall && tx_valid && tx_data !== prev_data) stall_err++;
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  always @(negedge clock) tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
    we_double = 0;
    stall_err = 0;
  endtask

  task automatic start(input logic ld, input logic dp, input logic [7:0] base, input logic [8:0] cnt);
    load_start = ld; dump_start = dp; base_addr = base; word_count = cnt;
    @(negedge clock);
    load_start = 1'b0; dump_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data = b; rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && t < 20) begin @(negedge clock); t++; end
    if (rx_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL rx_ready_timeout: rx_ready=%b required 1 for byte %02h", rx_ready, b);
    end
    @(negedge clock);
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done !== 1'b1 && t < budget) begin @(negedge clock); t++; end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_timeout: done=%b required 1 within %0d cycles", done, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({rx_ready, tx_valid, tx_data, mem_write_en, mem_addr, mem_wdata, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rx_ready=%b tx_valid=%b tx_data=%h we=%b addr=%h wdata=%h busy=%b done=%b required all 0",
               rx_ready, tx_valid, tx_data, mem_write_en, mem_addr, mem_wdata, busy, done);
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b rx_ready=%b required 0 0", busy, rx_ready);
    end
    $display("reset: outputs cleared, idle");
  endtask

  task automatic test_load();
    logic [7:0] bytes [4];
    bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    clear_logs();
    start(1'b1, 1'b0, 8'h10, 9'd2);
    checks++;
    if (busy !== 1'b1 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_start: busy=%b rx_ready=%b required 1 1", busy, rx_ready);
    end
    for (int i = 0; i < 4; i++) send_byte(bytes[i]);
    rx_valid = 1'b0;
    checks++;
    if (mem_write_en !== 1'b1 || mem_addr !== 8'h11 || mem_wdata !== 16'hABCD) begin
      errors++;
      $display("FAIL load_write2: we=%b addr=%h wdata=%h required 1 11 abcd", mem_write_en, mem_addr, mem_wdata);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_done: done=%b busy=%b required 1 1", done, busy);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_idle: done=%b busy=%b required 0 0", done, busy);
    end
    checks++;
    if (wr_addr_q.size() != 2 || we_double != 0) begin
      errors++;
      $display("FAIL load_count: writes=%0d double=%0d required 2 0", wr_addr_q.size(), we_double);
    end else begin
      checks++;
      if (wr_addr_q[0] !== 8'h10 || wr_data_q[0] !== 16'h1234 || wr_addr_q[1] !== 8'h11 || wr_data_q[1] !== 16'hABCD) begin
        errors++;
        $display("FAIL load_data: %h@%h %h@%h required 1234@10 abcd@11", wr_data_q[0], wr_addr_q[0], wr_data_q[1], wr_addr_q[1]);
      end
    end
    $display("load: base=10 count=2 writes=%0d", wr_addr_q.size());
  endtask

  task automatic test_dump();
    logic [7:0] exp_b [4];
    exp_b = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    clear_logs();
    tx_rand = 1'b1;
    start(1'b0, 1'b1, 8'h10, 9'd2);
    wait_done(200);
    checks++;
    if (tx_q.size() != 4) begin
      errors++;
      $display("FAIL dump_count: bytes_at_done=%0d required 4", tx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tx_q[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL dump_byte%0d: got=%h required %h", i, tx_q[i], exp_b[i]);
        end
      end
    end
    checks++;
    if (stall_err != 0 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL dump_stall: unstable=%0d writes=%0d required 0 0", stall_err, wr_addr_q.size());
    end
    tx_rand = 1'b0;
    @(negedge clock);
    $display("dump: base=10 count=2 bytes=%0d", tx_q.size());
  endtask

  task automatic test_wrap();
    logic [7:0]  exp_a [4];
    logic [15:0] exp_d [4];
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_d = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    clear_logs();
    start(1'b1, 1'b0, 8'hFE, 9'd4);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    rx_valid = 1'b0;
    wait_done(10);
    @(negedge clock);
    checks++;
    if (wr_addr_q.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: writes=%0d required 4", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL wrap_write%0d: %h@%h required %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_d[i], exp_a[i]);
        end
      end
    end
    $display("wrap: base=fe count=4 writes=%0d", wr_addr_q.size());
  endtask

  task automatic test_clamp();
    clear_logs();
    start(1'b1, 1'b0, 8'h00, 9'd300);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      send_byte(~8'(i));
    end
    rx_valid = 1'b0;
    wait_done(10);
    @(negedge clock);
    checks++;
    if (wr_addr_q.size() != 256 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clamp_count: writes=%0d busy=%b required 256 0", wr_addr_q.size(), busy);
    end else begin
      checks++;
      if (wr_data_q[0] !== 16'h00FF || wr_addr_q[255] !== 8'hFF || wr_data_q[255] !== 16'hFF00) begin
        errors++;
        $display("FAIL clamp_data: first=%h last=%h@%h required 00ff ff00@ff", wr_data_q[0], wr_data_q[255], wr_addr_q[255]);
      end
    end
    $display("clamp: count=300 writes=%0d", wr_addr_q.size());
  endtask

  task automatic test_both_start();
    clear_logs();
    start(1'b1, 1'b1, 8'h20, 9'd1);
    checks++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL both_start: rx_ready=%b tx_valid=%b required 1 0", rx_ready, tx_valid);
    end
    send_byte(8'h5A);
    send_byte(8'hA5);
    rx_valid = 1'b0;
    wait_done(10);
    @(negedge clock);
    checks++;
    if (wr_addr_q.size() != 1 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL both_count: writes=%0d tx=%0d required 1 0", wr_addr_q.size(), tx_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 8'h20 || wr_data_q[0] !== 16'h5AA5) begin
        errors++;
        $display("FAIL both_data: %h@%h required 5aa5@20", wr_data_q[0], wr_addr_q[0]);
      end
    end
    $display("both_start: load chosen, writes=%0d", wr_addr_q.size());
  endtask

  task automatic test_zero_count();
    int txv0;
    clear_logs();
    txv0 = txv_cnt;
    start(1'b1, 1'b0, 8'h40, 9'd0);
    checks++;
    if (done !== 1'b1 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_load_done: done=%b rx_ready=%b required 1 0", done, rx_ready);
    end
    @(negedge clock);
    start(1'b0, 1'b1, 8'h40, 9'd0);
    checks++;
    if (done !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_dump_done: done=%b tx_valid=%b required 1 0", done, tx_valid);
    end
    @(negedge clock);
    checks++;
    if (wr_addr_q.size() != 0 || txv_cnt != txv0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_activity: writes=%0d tx_valid_cycles=%0d busy=%b required 0 0 0",
               wr_addr_q.size(), txv_cnt - txv0, busy);
    end
    $display("zero_count: load and dump finished immediately");
  endtask

  task automatic test_start_while_busy();
    clear_logs();
    start(1'b1, 1'b0, 8'h30, 9'd1);
    start(1'b1, 1'b1, 8'h40, 9'd5);
    send_byte(8'hC3);
    send_byte(8'h3C);
    rx_valid = 1'b0;
    wait_done(10);
    @(negedge clock);
    checks++;
    if (wr_addr_q.size() != 1 || busy !== 1'b0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL busy_start_count: writes=%0d busy=%b tx=%0d required 1 0 0", wr_addr_q.size(), busy, tx_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 8'h30 || wr_data_q[0] !== 16'hC33C) begin
        errors++;
        $display("FAIL busy_start_data: %h@%h required c33c@30", wr_data_q[0], wr_addr_q[0]);
      end
    end
    $display("start_while_busy: restart ignored, writes=%0d", wr_addr_q.size());
  endtask

  task automatic test_reset_mid_load();
    clear_logs();
    start(1'b1, 1'b0, 8'h50, 9'd1);
    send_byte(8'h77);
    rx_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    checks++;
    if ({rx_ready, tx_valid, tx_data, mem_write_en, mem_addr, mem_wdata, busy, done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rx_ready=%b tx_valid=%b tx_data=%h we=%b addr=%h wdata=%h busy=%b done=%b required all 0",
               rx_ready, tx_valid, tx_data, mem_write_en, mem_addr, mem_wdata, busy, done);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_nowrite: writes=%0d required 0", wr_addr_q.size());
    end
    start(1'b1, 1'b0, 8'h50, 9'd1);
    send_byte(8'h12);
    send_byte(8'h9A);
    rx_valid = 1'b0;
    wait_done(10);
    @(negedge clock);
    checks++;
    if (wr_addr_q.size() != 1) begin
      errors++;
      $display("FAIL midreset_reload_count: writes=%0d required 1", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 8'h50 || wr_data_q[0] !== 16'h129A) begin
        errors++;
        $display("FAIL midreset_reload_data: %h@%h required 129a@50", wr_data_q[0], wr_addr_q[0]);
      end
    end
    $display("reset_mid_load: partial word dropped, reload writes=%0d", wr_addr_q.size());
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_load();
    test_dump();
    test_wrap();
    test_clamp();
    test_both_start();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
